// File: rtl/pi1_rr_arb_if.sv
// Bundle of the pi1 master-side and slave-side handshake signals handled by pi1_rr_arb.
// The arbiter connects through "master" (it masters the shared slave port); the environment uses "slave".
interface pi1_rr_arb_if #(
  parameter int MASTERCOUNT = 2,
  parameter int ARCHBITSZ   = 32
);
  localparam int SELBITSZ  = ARCHBITSZ / 8;
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(SELBITSZ);

  logic [2*MASTERCOUNT-1:0]         m_op_i;
  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i;
  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i;
  logic [SELBITSZ*MASTERCOUNT-1:0]  m_sel_i;
  logic [MASTERCOUNT-1:0]           m_rdy_o;
  logic [ARCHBITSZ-1:0]             m_data_o;
  logic [1:0]                       s_op_o;
  logic [ADDRBITSZ-1:0]             s_addr_o;
  logic [ARCHBITSZ-1:0]             s_data_o;
  logic [SELBITSZ-1:0]              s_sel_o;
  logic [ARCHBITSZ-1:0]             s_data_i;
  logic                             s_rdy_i;

  modport master (
    input  m_op_i, m_addr_i, m_data_i, m_sel_i, s_data_i, s_rdy_i,
    output m_rdy_o, m_data_o, s_op_o, s_addr_o, s_data_o, s_sel_o
  );

  modport slave (
    output m_op_i, m_addr_i, m_data_i, m_sel_i, s_data_i, s_rdy_i,
    input  m_rdy_o, m_data_o, s_op_o, s_addr_o, s_data_o, s_sel_o
  );
endinterface

// File: rtl/pi1_rr_arb.sv
// Single-clock round-robin arbiter sharing one pi1 slave port among MASTERCOUNT pi1 masters.
// A grant is held from command acceptance until the read response (if any) completes.
module pi1_rr_arb #(
  parameter int  MASTERCOUNT = 2,
  parameter int  ARCHBITSZ   = 32,
  localparam int GNTBITSZ    = (MASTERCOUNT > 1) ? $clog2(MASTERCOUNT) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pi1_rr_arb_if.master        bus,
  output logic [GNTBITSZ-1:0] gnt_o,
  output logic                busy_o
);
  localparam int SELBITSZ  = ARCHBITSZ / 8;
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(SELBITSZ);
  localparam logic [1:0] OP_NOOP = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [GNTBITSZ-1:0] LAST_IDX = GNTBITSZ'(MASTERCOUNT - 1);
  localparam logic [GNTBITSZ-1:0] ZERO_IDX = {GNTBITSZ{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [GNTBITSZ-1:0]    ptr_r, ptr_s, gnt_r, gnt_s, pick_s, ptr_inc_s;
  logic                   found_s;
  logic [1:0]             cur_op_s;
  logic [ADDRBITSZ-1:0]   cur_addr_s;
  logic [ARCHBITSZ-1:0]   cur_data_s;
  logic [SELBITSZ-1:0]    cur_sel_s;
  logic [1:0]             s_op_s;
  logic [ADDRBITSZ-1:0]   s_addr_s;
  logic [ARCHBITSZ-1:0]   s_data_s;
  logic [SELBITSZ-1:0]    s_sel_s;
  logic [MASTERCOUNT-1:0] m_rdy_s;

  // Fields of the currently granted master; gnt_r is always a valid index.
  assign cur_op_s   = bus.m_op_i[2*int'(gnt_r) +: 2];
  assign cur_addr_s = bus.m_addr_i[ADDRBITSZ*int'(gnt_r) +: ADDRBITSZ];
  assign cur_data_s = bus.m_data_i[ARCHBITSZ*int'(gnt_r) +: ARCHBITSZ];
  assign cur_sel_s  = bus.m_sel_i[SELBITSZ*int'(gnt_r) +: SELBITSZ];

  // Explicit wrap compare keeps non-power-of-2 counts correct.
  assign ptr_inc_s = (gnt_r == LAST_IDX) ? ZERO_IDX : gnt_r + GNTBITSZ'(1);

  // Round-robin pick: first requester scanning ptr, ptr+1, ... modulo MASTERCOUNT.
  always_comb begin
    int base_v;
    int idx_v;
    found_s = 1'b0;
    pick_s  = ptr_r;
    base_v  = 0;
    idx_v   = 0;
    for (int k = 0; k < MASTERCOUNT; k++) begin
      base_v = int'(ptr_r) + k;
      idx_v  = (base_v >= MASTERCOUNT) ? base_v - MASTERCOUNT : base_v;
      if (!found_s && (bus.m_op_i[2*idx_v +: 2] != OP_NOOP)) begin
        found_s = 1'b1;
        pick_s  = GNTBITSZ'(idx_v);
      end else begin
        pick_s  = pick_s;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    gnt_s    = gnt_r;
    s_op_s   = OP_NOOP;
    s_addr_s = {ADDRBITSZ{1'b0}};
    s_data_s = {ARCHBITSZ{1'b0}};
    s_sel_s  = {SELBITSZ{1'b0}};
    m_rdy_s  = {MASTERCOUNT{1'b0}};
    case (state_r)
      IDLE: begin
        if (found_s) begin
          gnt_s   = pick_s;
          state_s = CMD;
        end else begin
          state_s = IDLE;
        end
      end
      CMD: begin
        // A withdrawn request releases the grant without advancing ptr.
        if (cur_op_s == OP_NOOP) begin
          state_s = IDLE;
        end else begin
          s_op_s          = cur_op_s;
          s_addr_s        = cur_addr_s;
          s_data_s        = cur_data_s;
          s_sel_s         = cur_sel_s;
          m_rdy_s[gnt_r]  = bus.s_rdy_i;
          if (bus.s_rdy_i && (cur_op_s == OP_WR)) begin
            state_s = IDLE;
            ptr_s   = ptr_inc_s;
          end else if (bus.s_rdy_i) begin
            state_s = RESP;
          end else begin
            state_s = CMD;
          end
        end
      end
      RESP: begin
        m_rdy_s[gnt_r] = bus.s_rdy_i;
        if (bus.s_rdy_i) begin
          state_s = IDLE;
          ptr_s   = ptr_inc_s;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, round-robin pointer and grant registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      ptr_r   <= ZERO_IDX;
      gnt_r   <= ZERO_IDX;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      gnt_r   <= gnt_s;
    end
  end

  assign bus.s_op_o   = s_op_s;
  assign bus.s_addr_o = s_addr_s;
  assign bus.s_data_o = s_data_s;
  assign bus.s_sel_o  = s_sel_s;
  assign bus.m_rdy_o  = m_rdy_s;
  assign bus.m_data_o = bus.s_data_i;
  assign gnt_o        = gnt_r;
  assign busy_o       = (state_r != IDLE);
endmodule

// File: tb/tb_pi1_rr_arb.sv
// Self-checking bench for pi1_rr_arb with three masters: per-cycle vector table fed through
// an expectation queue, plus a hand-written asynchronous mid-response reset sequence.
module tb_pi1_rr_arb;
  localparam int MC = 3;
  localparam int AW = 32;

  typedef struct packed {
    logic        rst;
    logic [5:0]  mop;
    logic        srdy;
    logic [31:0] sdata;
    logic [1:0]  sop;
    logic [2:0]  mrdy;
    logic [1:0]  gnt;
    logic        busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  gnt;
  logic        busy;
  int          total = 0;
  int          bad = 0;
  vec_t        vecs[$];
  vec_t        sb[$];
  logic [29:0] addr_tab[MC];
  logic [31:0] data_tab[MC];
  logic [3:0]  sel_tab[MC];

  pi1_rr_arb_if #(.MASTERCOUNT(MC), .ARCHBITSZ(AW)) bus ();

  pi1_rr_arb #(.MASTERCOUNT(MC), .ARCHBITSZ(AW)) dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .bus    (bus.master),
    .gnt_o  (gnt),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [5:0] mop, logic srdy, logic [31:0] sd,
                              logic [1:0] sop, logic [2:0] mrdy, logic [1:0] g, logic b);
    vec_t v;
    v.rst = r; v.mop = mop; v.srdy = srdy; v.sdata = sd;
    v.sop = sop; v.mrdy = mrdy; v.gnt = g; v.busy = b;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    logic [61:0] exp_ds;
    addr_tab[0] = 30'h040; addr_tab[1] = 30'h100; addr_tab[2] = 30'h2A0;
    data_tab[0] = 32'hA0000000; data_tab[1] = 32'hA1111111; data_tab[2] = 32'hA2222222;
    sel_tab[0] = 4'hF; sel_tab[1] = 4'h3; sel_tab[2] = 4'hC;
    bus.m_op_i   = 6'b000000;
    bus.m_addr_i = {addr_tab[2], addr_tab[1], addr_tab[0]};
    bus.m_data_i = {data_tab[2], data_tab[1], data_tab[0]};
    bus.m_sel_i  = {sel_tab[2], sel_tab[1], sel_tab[0]};
    bus.s_rdy_i  = 1'b0;
    bus.s_data_i = 32'h0;

    // reset held with everyone reading, then first grant goes to master 0
    vecs.push_back(mk(1'b0, 6'b101010, 1'b0, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(1'b0, 6'b101010, 1'b0, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(1'b1, 6'b101010, 1'b0, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(1'b1, 6'b101010, 1'b0, 32'h0,        2'b10, 3'b000, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 6'b101010, 1'b1, 32'h0,        2'b10, 3'b001, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 6'b000000, 1'b1, 32'h11111111, 2'b00, 3'b001, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 6'b000000, 1'b0, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0));
    // all masters writing back to back: grants 0,1,2,0 with one idle cycle between
    vecs.push_back(mk(1'b0, 6'b000000, 1'b0, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(1'b1, 6'b010101, 1'b1, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(1'b1, 6'b010101, 1'b1, 32'h0,        2'b01, 3'b001, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 6'b010101, 1'b1, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(1'b1, 6'b010101, 1'b1, 32'h0,        2'b01, 3'b010, 2'd1, 1'b1));
    vecs.push_back(mk(1'b1, 6'b010101, 1'b1, 32'h0,        2'b00, 3'b000, 2'd1, 1'b0));
    vecs.push_back(mk(1'b1, 6'b010101, 1'b1, 32'h0,        2'b01, 3'b100, 2'd2, 1'b1));
    vecs.push_back(mk(1'b1, 6'b010101, 1'b1, 32'h0,        2'b00, 3'b000, 2'd2, 1'b0));
    vecs.push_back(mk(1'b1, 6'b010101, 1'b1, 32'h0,        2'b01, 3'b001, 2'd0, 1'b1));
    // master 1 read with three wait cycles; master 0 held off
    vecs.push_back(mk(1'b1, 6'b001010, 1'b0, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(1'b1, 6'b001010, 1'b1, 32'h0,        2'b10, 3'b010, 2'd1, 1'b1));
    vecs.push_back(mk(1'b1, 6'b001010, 1'b0, 32'h0,        2'b00, 3'b000, 2'd1, 1'b1));
    vecs.push_back(mk(1'b1, 6'b001010, 1'b0, 32'h0,        2'b00, 3'b000, 2'd1, 1'b1));
    vecs.push_back(mk(1'b1, 6'b001010, 1'b0, 32'h0,        2'b00, 3'b000, 2'd1, 1'b1));
    vecs.push_back(mk(1'b1, 6'b001010, 1'b1, 32'hDEADBEEF, 2'b00, 3'b010, 2'd1, 1'b1));
    vecs.push_back(mk(1'b1, 6'b000010, 1'b0, 32'h0,        2'b00, 3'b000, 2'd1, 1'b0));
    vecs.push_back(mk(1'b1, 6'b000010, 1'b1, 32'h0,        2'b10, 3'b001, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 6'b000000, 1'b1, 32'h12345678, 2'b00, 3'b001, 2'd0, 1'b1));
    // withdrawal: master 0 drops its read before ready; ptr must stay at 0
    vecs.push_back(mk(1'b0, 6'b000000, 1'b0, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(1'b1, 6'b000010, 1'b0, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(1'b1, 6'b000010, 1'b0, 32'h0,        2'b10, 3'b000, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 6'b000000, 1'b1, 32'h0,        2'b00, 3'b000, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 6'b000000, 1'b0, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(1'b1, 6'b001010, 1'b0, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(1'b1, 6'b001010, 1'b1, 32'h0,        2'b10, 3'b001, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 6'b001000, 1'b1, 32'h0,        2'b00, 3'b001, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 6'b000000, 1'b0, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0));
    // wrap: master 2 alone (RW), then masters 0 and 2 together -> master 0 wins
    vecs.push_back(mk(1'b1, 6'b110000, 1'b0, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(1'b1, 6'b110000, 1'b1, 32'h0,        2'b11, 3'b100, 2'd2, 1'b1));
    vecs.push_back(mk(1'b1, 6'b000000, 1'b1, 32'hCAFEF00D, 2'b00, 3'b100, 2'd2, 1'b1));
    vecs.push_back(mk(1'b1, 6'b110001, 1'b0, 32'h0,        2'b00, 3'b000, 2'd2, 1'b0));
    vecs.push_back(mk(1'b1, 6'b110001, 1'b1, 32'h0,        2'b01, 3'b001, 2'd0, 1'b1));
    vecs.push_back(mk(1'b1, 6'b110000, 1'b1, 32'h0,        2'b00, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(1'b1, 6'b110000, 1'b1, 32'h0,        2'b11, 3'b100, 2'd2, 1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n        = vecs[i].rst;
      bus.m_op_i   = vecs[i].mop;
      bus.s_rdy_i  = vecs[i].srdy;
      bus.s_data_i = vecs[i].sdata;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      exp_ds = (e.sop != 2'b00) ? {addr_tab[e.gnt], data_tab[e.gnt]} : 62'h0;
      chk("s_op", i, 64'(bus.s_op_o), 64'(e.sop));
      chk("m_rdy", i, 64'(bus.m_rdy_o), 64'(e.mrdy));
      chk("gnt", i, 64'(gnt), 64'(e.gnt));
      chk("busy", i, 64'(busy), 64'(e.busy));
      chk("s_addr_data", i, 64'({bus.s_addr_o, bus.s_data_o}), 64'(exp_ds));
      chk("s_sel", i, 64'(bus.s_sel_o), (e.sop != 2'b00) ? 64'(sel_tab[e.gnt]) : 64'h0);
      chk("m_data", i, 64'(bus.m_data_o), 64'(e.sdata));
    end

    // mid-response reset: outputs must clear with no clock edge
    @(posedge clk);
    #1;
    bus.m_op_i  = 6'b000000;
    bus.s_rdy_i = 1'b1;
    #1;
    chk("resp_busy", 100, 64'(busy), 64'h1);
    chk("resp_mrdy", 100, 64'(bus.m_rdy_o), 64'h4);
    chk("resp_gnt", 100, 64'(gnt), 64'h2);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 101, 64'(busy), 64'h0);
    chk("arst_mrdy", 101, 64'(bus.m_rdy_o), 64'h0);
    chk("arst_gnt", 101, 64'(gnt), 64'h0);
    chk("arst_sop", 101, 64'(bus.s_op_o), 64'h0);
    #10;
    rst_n = 1'b1;
    bus.s_rdy_i = 1'b0;
    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
